// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the lab3 codec-configuration I2C path: responder FSM
// states, the WM8731 device address and the WM8731 register map used by both
// the initiator and the responder.
// -----------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_A,
        BYTE1,
        ACK_1,
        BYTE2,
        ACK_2,
        IGNORE
    } i2c_rsp_state_t;

    // 7-bit device address of the WM8731 with CSB tied low.
    localparam logic [6:0] WM8731_ADDR = 7'h1A;

    // WM8731 register addresses (7-bit, carried in byte1[7:1]).
    localparam logic [6:0] WM8731_R_LLIN   = 7'h00;
    localparam logic [6:0] WM8731_R_RLIN   = 7'h01;
    localparam logic [6:0] WM8731_R_LHP    = 7'h02;
    localparam logic [6:0] WM8731_R_RHP    = 7'h03;
    localparam logic [6:0] WM8731_R_APATH  = 7'h04;
    localparam logic [6:0] WM8731_R_DPATH  = 7'h05;
    localparam logic [6:0] WM8731_R_PWR    = 7'h06;
    localparam logic [6:0] WM8731_R_IFACE  = 7'h07;
    localparam logic [6:0] WM8731_R_SRATE  = 7'h08;
    localparam logic [6:0] WM8731_R_ACTIVE = 7'h09;
    localparam logic [6:0] WM8731_R_RESET  = 7'h0F;

    // Address byte on the wire for a write to the given 7-bit device.
    function automatic logic [7:0] write_addr_byte(input logic [6:0] dev);
        return {dev, 1'b0};
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// -----------------------------------------------------------------------------
// i2c_sync_edge
// Multi-flop synchroniser for one asynchronous bus line followed by a
// previous-value flop, giving a clean level and single-cycle edge strobes.
//
// Parameters:
//   STAGES  synchroniser depth (minimum 2)
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   d       raw bus line
//   level   synchronised line level
//   rise    one-cycle strobe on a synchronised 0->1
//   fall    one-cycle strobe on a synchronised 1->0
// -----------------------------------------------------------------------------
module i2c_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: preset to 1, the idle level of a pulled-up I2C line, so
            // leaving reset on an idle bus never produces a spurious edge.
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the value
            // its predecessor held before this edge, which is what a
            // synchroniser chain requires.
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_responder.sv
// -----------------------------------------------------------------------------
// i2c_responder
// Write-only I2C target modelling the WM8731 register port. Oversamples
// SCL/SDA, detects START/STOP, ACKs its device address and turns each 2-byte
// write into a single register-write pulse.
//
// Parameters:
//   DEV_ADDR     7-bit device address that is ACKed
//   SYNC_STAGES  synchroniser depth for SCL and SDA (minimum 2)
// Ports:
//   i_clk       system clock, at least 8x SCL
//   i_rst_n     asynchronous active-low reset
//   i_sclk      I2C SCL from the initiator
//   io_sdat     I2C SDA, open-drain (driven 0 or z only)
//   o_wr_valid  one-cycle pulse per completed register write
//   o_reg_addr  register address of the last write (byte1[7:1])
//   o_reg_data  data of the last write ({byte1[0], byte2})
//   o_busy      high from a matched address until STOP
//   o_word_cnt  completed writes, saturating at 255
// -----------------------------------------------------------------------------
module i2c_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = WM8731_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sclk,
    inout  wire        io_sdat,
    output logic       o_wr_valid,
    output logic [6:0] o_reg_addr,
    output logic [8:0] o_reg_data,
    output logic       o_busy,
    output logic [7:0] o_word_cnt
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_scl (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .d     (i_sclk),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sda (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .d     (io_sdat),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    // SDA may only legally change while SCL is low, so any SDA edge seen with
    // SCL high is a bus condition, never data.
    logic start_ev, stop_ev;
    assign start_ev = sda_fall & scl_lvl;
    assign stop_ev  = sda_rise & scl_lvl;

    i2c_rsp_state_t state;
    logic [7:0]     shift_q;
    logic [2:0]     bit_cnt;
    logic [7:0]     byte1_q;
    logic           sda_drv;   // also marks the second half of an ACK slot

    // The byte as it will be once the bit on the current scl_rise is shifted in.
    logic [7:0] next_byte;
    assign next_byte = {shift_q[6:0], sda_lvl};

    assign io_sdat = sda_drv ? 1'b0 : 1'bz;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            shift_q    <= '0;
            bit_cnt    <= '0;
            byte1_q    <= '0;
            sda_drv    <= 1'b0;
            o_wr_valid <= 1'b0;
            o_reg_addr <= '0;
            o_reg_data <= '0;
            o_busy     <= 1'b0;
            o_word_cnt <= '0;
        end else begin
            o_wr_valid <= 1'b0;

            // STOP is checked first so it wins if both conditions coincide.
            if (stop_ev) begin
                state   <= IDLE;
                sda_drv <= 1'b0;
                bit_cnt <= '0;
                o_busy  <= 1'b0;
            end else if (start_ev) begin
                state   <= ADDR;
                sda_drv <= 1'b0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    ADDR, BYTE1, BYTE2: begin
                        if (scl_rise) begin
                            shift_q <= next_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                case (state)
                                    ADDR: begin
                                        if (next_byte == write_addr_byte(DEV_ADDR)) begin
                                            state  <= ACK_A;
                                            o_busy <= 1'b1;
                                        end else begin
                                            state <= IGNORE;
                                        end
                                    end
                                    BYTE1: begin
                                        byte1_q <= next_byte;
                                        state   <= ACK_1;
                                    end
                                    default: begin
                                        o_reg_addr <= byte1_q[7:1];
                                        o_reg_data <= {byte1_q[0], next_byte};
                                        o_wr_valid <= 1'b1;
                                        if (o_word_cnt != 8'hFF)
                                            o_word_cnt <= o_word_cnt + 8'd1;
                                        state <= ACK_2;
                                    end
                                endcase
                            end
                        end
                    end

                    // First scl_fall (end of bit 8) starts driving the ACK,
                    // second scl_fall (end of the 9th clock) releases it.
                    ACK_A, ACK_1, ACK_2: begin
                        if (scl_fall) begin
                            if (!sda_drv) begin
                                sda_drv <= 1'b1;
                            end else begin
                                sda_drv <= 1'b0;
                                bit_cnt <= '0;
                                case (state)
                                    ACK_A:   state <= BYTE1;
                                    ACK_1:   state <= BYTE2;
                                    default: state <= IGNORE;
                                endcase
                            end
                        end
                    end

                    IDLE, IGNORE: ;

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/i2c_responder.md
Name: i2c_responder

Overview:
- Bus-side I2C target (responder) for the lab3 codec-configuration path. It models the WM8731-style write-only register port that the I2C initiator programs.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches the 7-bit device address, ACKs it, and receives 2-byte register writes.
- Each write is presented as one register-write pulse. Used as a bench target for the initiator and as reusable RTL.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit device address that is ACKed (write address byte 0x34).
- SYNC_STAGES, 2, flops in the SCL/SDA input synchronisers (minimum 2).

Ports:
- i_clk  in  1  system clock; must be at least 8x the SCL frequency.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_sclk  in  1  I2C SCL driven by the initiator.
- io_sdat  inout  1  I2C SDA, open-drain: this block drives 1'b0 or 1'bz, never 1'b1.
- o_wr_valid  out  1  one-cycle pulse; a complete register write was received.
- o_reg_addr  out  7  register address of the last write (byte1[7:1]).
- o_reg_data  out  9  data of the last write ({byte1[0], byte2[7:0]}).
- o_busy  out  1  high between a matched START/address and STOP.
- o_word_cnt  out  8  number of completed writes, saturating at 255.

Behaviour:
- Reset (i_rst_n low, asynchronous): state IDLE, SDA released (z), o_wr_valid=0, o_reg_addr=0, o_reg_data=0, o_busy=0, o_word_cnt=0, synchronisers preset to 1. Reset mid-transfer aborts it with no write pulse.
- Input conditioning:
  - SCL and SDA each pass through SYNC_STAGES flops plus one previous-value flop.
  - scl_rise and scl_fall are single-cycle strobes.
  - START = synced SDA 1->0 while synced SCL=1. STOP = SDA 0->1 while SCL=1.
  - Bus events therefore act SYNC_STAGES+1 cycles after the pin change.
- Bit timing:
  - Data bits are sampled on scl_rise, MSB first, into an 8-bit shift register with a 3-bit counter.
  - ACK: SDA is driven low from the scl_fall that ends the 8th bit until the next scl_fall (the one ending the 9th clock), then released.
  - NACK: SDA stays released.
- FSM states: IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE.
  - IDLE -> ADDR on START.
  - ADDR, after 8 bits: if {DEV_ADDR,1'b0} matches, go to ACK_A and set o_busy=1; otherwise (address mismatch or R/W=1) go to IGNORE with NACK.
  - ACK_A -> BYTE1 -> ACK_1 -> BYTE2 -> ACK_2. ACK is driven in each ACK_* state.
  - ACK_2: o_reg_addr and o_reg_data are loaded and o_wr_valid pulses in the cycle after the 8th bit of byte2 is sampled. o_word_cnt increments at the same cycle.
  - After ACK_2 -> IGNORE: any further bytes are NACKed.
- Global transitions, from any state:
  - STOP -> IDLE, SDA released, o_busy=0.
  - START (repeated START) -> ADDR, bit counter cleared, partial byte discarded, no write pulse.
- If START and STOP would both be flagged in one cycle (impossible with a clean bus), STOP wins.
- An SDA change while SCL=1 inside a data bit is treated as START or STOP, never as data.
- o_word_cnt saturates at 8'hFF; it never wraps.
- Outputs are registered; o_reg_addr and o_reg_data hold their values until the next write.

Decomposition:
- Shared package i2c_pkg holds:
  - the state enum i2c_rsp_state_t;
  - the WM8731 address constant WM8731_ADDR = 7'h1A;
  - the WM8731 register address constants shared with the initiator.
- Sub-module i2c_sync_edge: parameterised synchroniser plus rise/fall detector, instantiated once for SCL and once for SDA.

Test Plan:
- Single write: initiator sends START, 0x34, 0x00, 0x97, STOP -> three ACKs; one o_wr_valid pulse; o_reg_addr=7'h00, o_reg_data=9'h097; o_word_cnt=1; o_busy drops after STOP.
- Full codec init sequence (10 writes including 0x1E/0x00 reset and 0x12/0x01 active) -> 10 pulses in order with matching addr/data (last 7'h09, 9'h001); o_word_cnt=10.
- Wrong address 0x36 followed by 2 bytes -> SDA never driven low; no pulse; o_busy stays 0.
- Repeated START after byte1 of a write, then a fresh 0x34, 0x08, 0x15 -> exactly one pulse with addr=7'h04, data=9'h015.
- i_rst_n pulsed low during BYTE2 -> SDA released immediately; all outputs return to 0; the next complete transaction decodes correctly.
- 260 back-to-back writes -> o_word_cnt saturates at 255; extra bytes after byte2 within one transfer are NACKed.
